// File: rtl/fun_sweep_ctrl.sv
// Sweeps all 16 dual-rail input vectors into the `fun` gate, samples its output
// and compares against EXPECTED. Optional break-before-make gap: FUN_SWEEP_BBM_EN.
module fun_sweep_ctrl #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'h5CDD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        fun_out,
  output logic        a,
  output logic        a_not,
  output logic        b,
  output logic        b_not,
  output logic        c,
  output logic        c_not,
  output logic        d,
  output logic        d_not,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] captured,
  output logic [4:0]  err_count,
  output logic [3:0]  vec_idx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SAMPLE = 3'd2,
    S_DONE   = 3'd3
`ifdef FUN_SWEEP_BBM_EN
    , S_GAP  = 3'd4
`endif
  } state_t;

  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  vec_idx_q, vec_idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] captured_q, captured_d;
  logic [4:0]  err_q, err_d;
  // Rail order: {a, b, c, d, a_not, b_not, c_not, d_not}
  logic [7:0]  rails_q, rails_d;

  always_comb begin
    state_d    = state_q;
    vec_idx_d  = vec_idx_q;
    cnt_d      = cnt_q;
    captured_d = captured_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_DRIVE;
          vec_idx_d  = 4'd0;
          cnt_d      = SETTLE_RELOAD;
          captured_d = 16'h0000;
          err_d      = 5'd0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == 8'd0) state_d = S_SAMPLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_SAMPLE: begin
        captured_d[vec_idx_q] = fun_out;
        // Case-inequality so an undriven/contended output is never taken as a match
        if (fun_out !== EXPECTED[vec_idx_q]) err_d = err_q + 5'd1;
        if (vec_idx_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          vec_idx_d = vec_idx_q + 4'd1;
`ifdef FUN_SWEEP_BBM_EN
          state_d   = S_GAP;
`else
          cnt_d     = SETTLE_RELOAD;
          state_d   = S_DRIVE;
`endif
        end
      end
`ifdef FUN_SWEEP_BBM_EN
      S_GAP: begin
        cnt_d   = SETTLE_RELOAD;
        state_d = S_DRIVE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Rails are registered from the next-state view so they change exactly at the edge
    rails_d = {vec_idx_d, ~vec_idx_d};
`ifdef FUN_SWEEP_BBM_EN
    if (state_d == S_GAP) rails_d = 8'h00;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_idx_q  <= 4'd0;
      cnt_q      <= 8'd0;
      captured_q <= 16'h0000;
      err_q      <= 5'd0;
      rails_q    <= 8'h0F;
    end else begin
      state_q    <= state_d;
      vec_idx_q  <= vec_idx_d;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      err_q      <= err_d;
      rails_q    <= rails_d;
    end
  end

  assign {a, b, c, d, a_not, b_not, c_not, d_not} = rails_q;

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == 5'd0);
  assign captured  = captured_q;
  assign err_count = err_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_fun_sweep_ctrl.sv
// Directed bench for fun_sweep_ctrl with a behavioural model of the `fun` gate.
module tb_fun_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        fun_out;
  logic        a, a_not, b, b_not, c, c_not, d, d_not;
  logic        busy, done, pass;
  logic [15:0] captured;
  logic [4:0]  err_count;
  logic [3:0]  vec_idx;

  logic force_one = 1'b0;
  logic corrupt3  = 1'b0;

  int total  = 0;
  int passed = 0;
  int done_edge, rail_err, gap_cnt;
  logic busy0, done0;

`ifdef FUN_SWEEP_BBM_EN
  localparam int DONE_EDGE = 63;
  localparam int GAPS      = 15;
`else
  localparam int DONE_EDGE = 48;
  localparam int GAPS      = 0;
`endif

  always #5 clk = ~clk;

  assign fun_out = force_one ? 1'b1 :
                   (corrupt3 && ({a, b, c, d} == 4'd3)) ? 1'b0 :
                   ~((a | d) & (~b | d) & (a | ~c) & (b | ~c));

  fun_sweep_ctrl #(.SETTLE(2), .EXPECTED(16'h5CDD)) dut (
    .clk(clk), .rst(rst), .start(start), .fun_out(fun_out),
    .a(a), .a_not(a_not), .b(b), .b_not(b_not),
    .c(c), .c_not(c_not), .d(d), .d_not(d_not),
    .busy(busy), .done(done), .pass(pass),
    .captured(captured), .err_count(err_count), .vec_idx(vec_idx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected rails after edge n of a sweep with SETTLE=2
  task automatic check_rails(input int n);
    logic [3:0] v, vn, ev;
    logic       gap;
    v  = {a, b, c, d};
    vn = {a_not, b_not, c_not, d_not};
`ifdef FUN_SWEEP_BBM_EN
    if (n < 3) begin
      ev = 4'd0; gap = 1'b0;
    end else begin
      gap = (((n - 3) % 4) == 0);
      ev  = 4'(1 + (n - 3) / 4);
    end
`else
    ev  = 4'(n / 3);
    gap = 1'b0;
`endif
    if (gap) begin
      if (v !== 4'd0 || vn !== 4'd0) rail_err++;
      else gap_cnt++;
    end else if (v !== ev || vn !== ~v) begin
      rail_err++;
    end
  endtask

  // Start a sweep (edge 0), pulse start again at edges p1/p2, stop early before edge stop_at
  task automatic sweep(input int p1, input int p2, input int stop_at);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy; done0 = done;
    rail_err = 0; gap_cnt = 0; done_edge = -1;
    check_rails(0);
    for (int n = 1; n <= 200; n++) begin
      if (n == stop_at) return;
      start = (n == p1) || (n == p2);
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        done_edge = n;
        return;
      end
      check_rails(n);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #20;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_captured", 32'(captured), 32'h0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_vec", 32'(vec_idx), 32'd0);
    check("rst_rails", 32'({a, b, c, d, a_not, b_not, c_not, d_not}), 32'h0F);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // Good gate
    sweep(-1, -1, -1);
    check("s1_busy0", 32'(busy0), 32'd1);
    check("s1_done0", 32'(done0), 32'd0);
    check("s1_done_edge", 32'(done_edge), 32'(DONE_EDGE));
    check("s1_captured", 32'(captured), 32'h5CDD);
    check("s1_err", 32'(err_count), 32'd0);
    check("s1_pass", 32'(pass), 32'd1);
    check("s1_busy_end", 32'(busy), 32'd0);
    check("s1_vec", 32'(vec_idx), 32'd15);
    check("s1_rail_err", 32'(rail_err), 32'd0);
    check("s1_gaps", 32'(gap_cnt), 32'(GAPS));
    check("s1_rails_done", 32'({a, b, c, d, a_not, b_not, c_not, d_not}), 32'hF0);

    // Stuck-at-1 output
    force_one = 1'b1;
    sweep(-1, -1, -1);
    force_one = 1'b0;
    check("s2_done_edge", 32'(done_edge), 32'(DONE_EDGE));
    check("s2_captured", 32'(captured), 32'hFFFF);
    check("s2_err", 32'(err_count), 32'd6);
    check("s2_pass", 32'(pass), 32'd0);

    // Start pulses while busy are ignored
    sweep(5, 20, -1);
    check("s3_done_edge", 32'(done_edge), 32'(DONE_EDGE));
    check("s3_captured", 32'(captured), 32'h5CDD);
    check("s3_err", 32'(err_count), 32'd0);
    check("s3_rail_err", 32'(rail_err), 32'd0);

    // Asynchronous reset mid-sweep (after edge 25)
    sweep(-1, -1, 26);
    check("s4_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("s4_busy", 32'(busy), 32'd0);
    check("s4_done", 32'(done), 32'd0);
    check("s4_captured", 32'(captured), 32'h0);
    check("s4_err", 32'(err_count), 32'd0);
    check("s4_vec", 32'(vec_idx), 32'd0);
    check("s4_rails", 32'({a, b, c, d, a_not, b_not, c_not, d_not}), 32'h0F);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("s4_no_resume", 32'(busy), 32'd0);
    sweep(-1, -1, -1);
    check("s4b_done_edge", 32'(done_edge), 32'(DONE_EDGE));
    check("s4b_captured", 32'(captured), 32'h5CDD);
    check("s4b_pass", 32'(pass), 32'd1);

    // Restart from DONE with the gate corrupted at vector 3
    corrupt3 = 1'b1;
    sweep(-1, -1, -1);
    corrupt3 = 1'b0;
    check("s5_done0", 32'(done0), 32'd0);
    check("s5_busy0", 32'(busy0), 32'd1);
    check("s5_done_edge", 32'(done_edge), 32'(DONE_EDGE));
    check("s5_captured", 32'(captured), 32'h5CD5);
    check("s5_err", 32'(err_count), 32'd1);
    check("s5_pass", 32'(pass), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fun_sweep_ctrl.md
Name: fun_sweep_ctrl

Overview:
- Sequential stimulus/capture stage sitting directly upstream of the dual-rail switch-level CMOS gate `fun` (inputs a/a_not … d/d_not, output out). It also consumes that gate's output.
- On `start`, it sweeps all 16 input combinations as complementary rail pairs and waits a programmable settle time per vector.
- For each vector it samples `out`, builds the observed 16-bit truth table and compares it bit-by-bit against an expected table.
- Used for on-chip/bench self-check of the gate.

Parameters:
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..255.
- EXPECTED, 16'h5CDD, expected truth table; bit i = expected out for vector index i = {a,b,c,d} (a is MSB). The default matches out = ~((a|d)&(~b|d)&(a|~c)&(b|~c)).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a sweep
- fun_out  input  1  `out` of the gate under drive
- a, a_not, b, b_not, c, c_not, d, d_not  output  1 each  dual-rail drive to the gate
- busy  output  1  sweep in progress
- done  output  1  sweep complete; held until the next start
- pass  output  1  valid while done=1; 1 when err_count==0
- captured  output  16  observed truth table
- err_count  output  5  number of mismatching vectors, 0..16
- vec_idx  output  4  current vector index

Behaviour:
- Reset (async, any state): state=IDLE, vec_idx=0, captured=0, err_count=0, busy=0, done=0, pass=0.
  - Rails at reset: a=b=c=d=0, a_not=b_not=c_not=d_not=1.
- Rail encoding outside gap cycles: {a,b,c,d}=vec_idx; each x_not = ~x. Rails are registered outputs, glitch-free.
- States: IDLE, DRIVE, SAMPLE, GAP (optional feature only), DONE.
- IDLE/DONE + start=1 at edge E0:
  - go to DRIVE; vec_idx=0; captured=0; err_count=0; settle counter=SETTLE-1.
  - busy=1 and done=0 from E0 onward.
- DRIVE: counter decrements each edge. When counter==0, go to SAMPLE. DRIVE lasts exactly SETTLE cycles.
- SAMPLE (one cycle) at its edge:
  - captured[vec_idx] <= fun_out.
  - If fun_out != EXPECTED[vec_idx], err_count increments.
  - If vec_idx==15: go to DONE.
  - Otherwise: vec_idx+1, counter reloads to SETTLE-1, go to DRIVE.
- Latency: each vector costs SETTLE+1 cycles. done rises at edge E0+16*(SETTLE+1); E0+48 for the default.
- DONE: busy=0, done=1, pass=(err_count==0). captured, err_count and vec_idx=15 are held; rails keep driving vector 15.
- start while busy=1: ignored, with no effect on counters.
- start in DONE: restarts the sweep exactly as from IDLE.
- fun_out X/Z at a SAMPLE edge: counted as a mismatch (compare with !==). captured takes the sampled value.
- err_count saturates naturally at 16 (5 bits); no wrap is possible.
- Reset asserted mid-sweep: immediate return to reset values. A sweep never resumes; a new start is required.

Optional Feature:
- Macro: FUN_SWEEP_BBM_EN (break-before-make).
- When defined:
  - Between SAMPLE of vector i (i<15) and DRIVE of vector i+1, insert one GAP cycle with all eight rails = 0 (no rail pair active).
  - Per-vector cost for vectors 1..15 becomes SETTLE+2; done rises at E0+16*(SETTLE+1)+15 (63 for the default).
  - No gap occurs before vector 0 or after vector 15.
- When undefined: the GAP state does not exist, and rails change directly between vectors.

Test Plan:
- Reset then start pulse; bench models the gate as out=~((a|d)&(~b|d)&(a|~c)&(b|~c)), SETTLE=2 → done at edge 48, captured=16'h5CDD, err_count=0, pass=1.
- Same stimulus with fun_out forced to 1 → captured=16'hFFFF, err_count=6 (vectors 1,5,8,9,13,15), pass=0.
- Check rails every cycle of the sweep → x_not==~x always, and {a,b,c,d} steps 0..15, each held SETTLE+1 cycles. Under FUN_SWEEP_BBM_EN: exactly 15 all-zero cycles, done at edge 63.
- Pulse start at cycles 5 and 20 of a sweep → no restart; done still at edge 48.
- Assert rst at cycle 25 → busy=0, done=0, captured=0, err_count=0, rails at vector 0 immediately (async). A later start gives a full correct sweep.
- After done, start again with the gate model corrupted at vector 3 (out=0) → captured=16'h5CD5, err_count=1, pass=0; done drops at the restart edge.
